cla_carry_pipe: RTL and testbench

CLA_CARRY_PIPE -- requirements
Module: cla_carry_pipe

---
 rtl/cla_pkg.sv | 44 ++++
 rtl/cla_carry_pipe_if.sv | 27 ++
 rtl/cla_prefix_cell.sv | 13 +
 rtl/cla_carry_pipe.sv | 143 ++++++++++++++
 tb/tb_cla_carry_pipe.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined Kogge-Stone carry network.
package cla_pkg;

  localparam int unsigned CLA_WIDTH  = 32;
  localparam int unsigned CLA_LEVELS = 5;

  typedef struct packed {
    logic g;
    logic p;
  } cla_pg_t;

  typedef cla_pg_t [CLA_WIDTH-1:0] cla_pg_vec_t;

  typedef struct packed {
    logic                 valid;
    logic [CLA_WIDTH-1:0] p;
    logic [CLA_WIDTH-1:0] g_grp;
    logic [CLA_WIDTH-1:0] p_grp;
    logic                 cin;
  } cla_stage_t;

  function automatic cla_pg_vec_t cla_zip(input logic [CLA_WIDTH-1:0] g_grp,
                                          input logic [CLA_WIDTH-1:0] p_grp);
    cla_pg_vec_t v;
    for (int i = 0; i < int'(CLA_WIDTH); i++) begin
      v[i].g = g_grp[i];
      v[i].p = p_grp[i];
    end
    return v;
  endfunction

  function automatic logic [CLA_WIDTH-1:0] cla_g_of(input cla_pg_vec_t v);
    logic [CLA_WIDTH-1:0] r;
    for (int i = 0; i < int'(CLA_WIDTH); i++) r[i] = v[i].g;
    return r;
  endfunction

  function automatic logic [CLA_WIDTH-1:0] cla_p_of(input cla_pg_vec_t v);
    logic [CLA_WIDTH-1:0] r;
    for (int i = 0; i < int'(CLA_WIDTH); i++) r[i] = v[i].p;
    return r;
  endfunction

endpackage

// File: rtl/cla_carry_pipe_if.sv
// Valid/ready input (p, g, cin) and output (sum, carry, cout, ovf) bundle.
interface cla_carry_pipe_if;
  import cla_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [CLA_WIDTH-1:0] p;
  logic [CLA_WIDTH-1:0] g;
  logic                 cin;
  logic                 out_valid;
  logic                 out_ready;
  logic [CLA_WIDTH-1:0] sum;
  logic [CLA_WIDTH-1:0] carry;
  logic                 cout;
  logic                 ovf;

  modport slave (
    input  in_valid, p, g, cin, out_ready,
    output in_ready, out_valid, sum, carry, cout, ovf
  );

  modport master (
    output in_valid, p, g, cin, out_ready,
    input  in_ready, out_valid, sum, carry, cout, ovf
  );

endinterface

// File: rtl/cla_prefix_cell.sv
// Prefix combine: (G,P) o (G',P') = (G | P&G', P&P'), hi is the more significant group.
module cla_prefix_cell
  import cla_pkg::*;
(
  input  cla_pg_t i_hi,
  input  cla_pg_t i_lo,
  output cla_pg_t o_pg_c
);

  assign o_pg_c.g = i_hi.g | (i_hi.p & i_lo.g);
  assign o_pg_c.p = i_hi.p & i_lo.p;

endmodule

// File: rtl/cla_carry_pipe.sv
// Three-stage Kogge-Stone carry pipeline: levels 1-2 | levels 3-4 | level 5 + sum.
module cla_carry_pipe
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  cla_carry_pipe_if.slave   bus
);

  localparam int unsigned W = CLA_WIDTH;

  if (WIDTH != CLA_WIDTH) begin : g_width_chk
    $error("cla_carry_pipe: WIDTH must be 32");
  end

  cla_stage_t     r_s1;
  cla_stage_t     r_s2;
  logic           r_s3_valid;
  logic [W-1:0]   r_sum;
  logic [W-1:0]   r_carry;
  logic           r_cout;
  logic           r_ovf;

  logic           w_s1_ld;
  logic           w_s2_ld;
  logic           w_s3_ld;

  cla_pg_vec_t    w_l0;
  cla_pg_vec_t    w_l1;
  cla_pg_vec_t    w_l2;
  cla_pg_vec_t    w_l3;
  cla_pg_vec_t    w_l4;
  cla_pg_vec_t    w_l5;
  cla_pg_vec_t    w_s1_pg;
  cla_pg_vec_t    w_s2_pg;
  logic [W-1:0]   w_c;
  logic           w_unused_top_p;

  // cin folds into bit 0, so every final group G is that bit's carry-out
  always_comb begin
    w_l0      = cla_zip(bus.g, bus.p);
    w_l0[0].g = bus.g[0] | (bus.p[0] & bus.cin);
    w_l0[0].p = 1'b0;
  end

  assign w_s1_pg = cla_zip(r_s1.g_grp, r_s1.p_grp);
  assign w_s2_pg = cla_zip(r_s2.g_grp, r_s2.p_grp);

  for (genvar l = 1; l <= int'(CLA_LEVELS); l++) begin : g_lvl
    localparam int SPAN = 1 << (l - 1);
    cla_pg_vec_t w_src;
    cla_pg_vec_t w_dst;

    if (l == 1) begin : g_src1
      assign w_src = w_l0;
    end else if (l == 2) begin : g_src2
      assign w_src = w_l1;
    end else if (l == 3) begin : g_src3
      assign w_src = w_s1_pg;
    end else if (l == 4) begin : g_src4
      assign w_src = w_l3;
    end else begin : g_src5
      assign w_src = w_s2_pg;
    end

    for (genvar i = 0; i < int'(W); i++) begin : g_bit
      if (i >= SPAN) begin : g_cell
        cla_prefix_cell u_cell (
          .i_hi   (w_src[i]),
          .i_lo   (w_src[i-SPAN]),
          .o_pg_c (w_dst[i])
        );
      end else begin : g_pass
        assign w_dst[i] = w_src[i];
      end
    end

    if (l == 1) begin : g_dst1
      assign w_l1 = w_dst;
    end else if (l == 2) begin : g_dst2
      assign w_l2 = w_dst;
    end else if (l == 3) begin : g_dst3
      assign w_l3 = w_dst;
    end else if (l == 4) begin : g_dst4
      assign w_l4 = w_dst;
    end else begin : g_dst5
      assign w_l5 = w_dst;
    end
  end

  assign w_c = cla_g_of(w_l5);
  // Full-span group propagate includes bit -1 (p=0), so it carries no information
  assign w_unused_top_p = ^cla_p_of(w_l5);

  // Elastic advance: a stage loads when empty or when its successor loads
  assign w_s3_ld = !r_s3_valid || bus.out_ready;
  assign w_s2_ld = !r_s2.valid || w_s3_ld;
  assign w_s1_ld = !r_s1.valid || w_s2_ld;

  assign bus.in_ready  = rst_n && w_s1_ld;
  assign bus.out_valid = r_s3_valid;
  assign bus.sum       = r_sum;
  assign bus.carry     = r_carry;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_s3_valid <= 1'b0;
      r_sum      <= '0;
      r_carry    <= '0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_s1_ld) begin
        r_s1.valid <= bus.in_valid;
        r_s1.p     <= bus.p;
        r_s1.g_grp <= cla_g_of(w_l2);
        r_s1.p_grp <= cla_p_of(w_l2);
        r_s1.cin   <= bus.cin;
      end
      if (w_s2_ld) begin
        r_s2.valid <= r_s1.valid;
        r_s2.p     <= r_s1.p;
        r_s2.g_grp <= cla_g_of(w_l4);
        r_s2.p_grp <= cla_p_of(w_l4);
        r_s2.cin   <= r_s1.cin;
      end
      if (w_s3_ld) begin
        r_s3_valid <= r_s2.valid;
        r_carry    <= w_c;
        r_sum      <= r_s2.p ^ {w_c[W-2:0], r_s2.cin};
        r_cout     <= w_c[W-1];
        r_ovf      <= w_c[W-1] ^ w_c[W-2];
      end
    end
  end

endmodule

// File: tb/tb_cla_carry_pipe.sv
// Randomized valid/ready bench for cla_carry_pipe against an A+B+cin arithmetic model.
module tb_cla_carry_pipe;
  import cla_pkg::*;

  typedef struct {
    logic [CLA_WIDTH-1:0] sum;
    logic [CLA_WIDTH-1:0] carry;
    logic                 cout;
    logic                 ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  cla_carry_pipe_if u_if ();

  cla_carry_pipe #(.WIDTH(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] tb_a;
  logic [31:0] tb_b;
  logic        tb_cin;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: plain 33-bit addition; bit carries recovered from s = a ^ b ^ c_in
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic ci);
    logic [32:0] s;
    exp_t e;
    s = {1'b0, a} + {1'b0, b} + {32'd0, ci};
    e.sum = s[31:0];
    e.cout = s[32];
    for (int i = 0; i < 31; i++) e.carry[i] = s[i+1] ^ a[i+1] ^ b[i+1];
    e.carry[31] = s[32];
    e.ovf = (a[31] == b[31]) && (s[31] != a[31]);
    return e;
  endfunction

  task automatic set_in(input logic v, input logic [31:0] a, input logic [31:0] b, input logic ci);
    tb_a = a;
    tb_b = b;
    tb_cin = ci;
    u_if.in_valid = v;
    u_if.p = a ^ b;
    u_if.g = a & b;
    u_if.cin = ci;
  endtask

  task automatic set_rand(input logic v);
    logic [31:0] a;
    logic [31:0] b;
    a = $urandom;
    case ($urandom_range(0, 7))
      0: b = ~a;
      1: b = a;
      2: b = 32'd0;
      default: b = $urandom;
    endcase
    set_in(v, a, b, 1'($urandom));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: inputs accepted and results emitted are both decided at the next edge
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (u_if.in_valid && u_if.in_ready) exp_q.push_back(model(tb_a, tb_b, tb_cin));
      if (u_if.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", 64'(u_if.out_valid), 64'd0);
        end else begin
          mon_e = exp_q[0];
          chk("sb_sum", 64'(u_if.sum), 64'(mon_e.sum));
          chk("sb_carry", 64'(u_if.carry), 64'(mon_e.carry));
          chk("sb_cout_ovf", 64'({u_if.cout, u_if.ovf}), 64'({mon_e.cout, mon_e.ovf}));
          if (u_if.out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic single(input logic [31:0] a, input logic [31:0] b, input logic ci,
                        input logic [31:0] es, input logic [31:0] ec, input logic eco,
                        input logic eov);
    set_in(1'b1, a, b, ci);
    tick();
    set_in(1'b0, a, b, ci);
    chk("lat_c1_valid", 64'(u_if.out_valid), 64'd0);
    tick();
    chk("lat_c2_valid", 64'(u_if.out_valid), 64'd0);
    tick();
    chk("lat_c3_valid", 64'(u_if.out_valid), 64'd1);
    chk("dir_sum", 64'(u_if.sum), 64'(es));
    chk("dir_carry", 64'(u_if.carry), 64'(ec));
    chk("dir_cout", 64'(u_if.cout), 64'(eco));
    chk("dir_ovf", 64'(u_if.ovf), 64'(eov));
    tick();
    chk("dir_consumed", 64'(u_if.out_valid), 64'd0);
  endtask

  task automatic finish_offer();
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      acc = u_if.in_valid && u_if.in_ready;
      tick();
    end
    chk("offer_accepted", 64'(acc), 64'd1);
    set_in(1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic drain();
    u_if.out_ready = 1'b1;
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) tick();
    tick();
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    chk("drain_out_valid", 64'(u_if.out_valid), 64'd0);
  endtask

  initial begin
    int  acc_cnt;
    logic acc;

    set_in(1'b0, 32'd0, 32'd0, 1'b0);
    u_if.out_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 64'(u_if.out_valid), 64'd0);
    chk("rst_in_ready", 64'(u_if.in_ready), 64'd0);
    chk("rst_sum", 64'(u_if.sum), 64'd0);
    chk("rst_carry", 64'(u_if.carry), 64'd0);
    chk("rst_cout_ovf", 64'({u_if.cout, u_if.ovf}), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 64'(u_if.in_ready), 64'd1);

    single(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    single(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1);
    single(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1);

    // Eight back-to-back inputs with no backpressure
    u_if.out_ready = 1'b1;
    for (int j = 0; j < 12; j++) begin
      if (j < 8) set_rand(1'b1);
      else set_in(1'b0, 32'd0, 32'd0, 1'b0);
      tick();
      chk($sformatf("b2b_out_valid_%0d", j), 64'(u_if.out_valid), 64'(j >= 2 && j <= 9));
    end
    drain();

    // Stall output for five cycles while offering inputs
    u_if.out_ready = 1'b0;
    acc_cnt = 0;
    set_rand(1'b1);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      acc = u_if.in_valid && u_if.in_ready;
      tick();
      chk($sformatf("stall_in_ready_%0d", j), 64'(u_if.in_ready), 64'(j < 2));
      if (acc) begin
        acc_cnt++;
        set_rand(1'b1);
      end
    end
    chk("stall_accepts", 64'(acc_cnt), 64'd3);
    u_if.out_ready = 1'b1;
    finish_offer();
    drain();

    // Reset with three results in flight
    u_if.out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      set_rand(1'b1);
      tick();
    end
    set_in(1'b0, 32'd0, 32'd0, 1'b0);
    chk("mid_full_out_valid", 64'(u_if.out_valid), 64'd1);
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    chk("mid_rst_out_valid", 64'(u_if.out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(u_if.in_ready), 64'd0);
    chk("mid_rst_sum", 64'(u_if.sum), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_in_ready", 64'(u_if.in_ready), 64'd1);
    u_if.out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("mid_no_leak", 64'(u_if.out_valid), 64'd0);
    end

    // Random valid/ready traffic
    set_in(1'b0, 32'd0, 32'd0, 1'b0);
    for (int c = 0; c < 30000; c++) begin
      @(negedge clk);
      acc = u_if.in_valid && u_if.in_ready;
      tick();
      if (acc || !u_if.in_valid) set_rand(1'($urandom_range(0, 99) < 70));
      u_if.out_ready = ($urandom_range(0, 99) < 70);
    end
    if (u_if.in_valid) finish_offer();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d pending results", exp_q.size());
    $fatal(1, "watchdog");
  end

endmodule
